instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction Fetch stage of the single-issue MIPS pipeline. It owns the PC, issues one-outstanding requests to instruction memory, and drives the IF/ID pipeline register (instr, PC_4) consumed by InstrDecod. It accepts redirects (taken branch, jumpDest) and decode stalls, and has a one-entry skid buffer so memory responses are never lost.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
NOP_INSTR, 32'h0000_0000, instruction word driven on instr when IF/ID is empty or flushed.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  request to instruction memory; held until response.
imem_addr  output  32  word-aligned fetch address; stable while a request is outstanding.
imem_rvalid  input  1  response valid; one pulse per request, latency >=1 cycle.
imem_rdata  input  32  instruction word, valid with imem_rvalid.
id_stall  input  1  decode cannot accept a new instruction this cycle.
redirect  input  1  squash fetched instructions and restart at redirect_pc.
redirect_pc  input  32  new PC (branch target or jumpDest); bits [1:0] ignored, treated as 0.
instr  output  32  IF/ID instruction to decode.
PC_4  output  32  IF/ID PC+4 of instr.
id_valid  output  1  instr/PC_4 hold a live instruction.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, req_addr=RESET_PC, state=FETCH, instr=NOP_INSTR, PC_4=0, id_valid=0, skid empty. imem_req=1 in the first cycle after release.
- "Slot free" = !id_valid || !id_stall.
- States: FETCH, HOLD, DROP. Outputs registered except imem_req/imem_addr (decoded from state/req_addr).
- FETCH: imem_req=1, imem_addr=req_addr(=pc).
  - rvalid && !redirect && slot free: instr=rdata, PC_4=pc+4, id_valid=1; pc,req_addr=pc+4; stay FETCH. Back-to-back 1-cycle memory gives one instruction per cycle.
  - rvalid && !redirect && !slot free: skid={rdata, pc+4}; pc,req_addr=pc+4; go HOLD.
  - !rvalid && slot free: id_valid=0 (instr=NOP_INSTR).
  - !rvalid && !slot free: IF/ID held unchanged.
  - redirect && rvalid: discard response; pc,req_addr=redirect_pc; id_valid=0; stay FETCH.
  - redirect && !rvalid: pc=redirect_pc (req_addr unchanged); id_valid=0; go DROP.
- HOLD: imem_req=0. When !id_stall: IF/ID=skid, id_valid=1, skid empty, go FETCH. While id_stall: hold everything.
  - redirect: discard skid, id_valid=0, pc,req_addr=redirect_pc, go FETCH.
- DROP: imem_req=1, imem_addr=req_addr (old address, protocol stability). id_valid=0.
  - rvalid: discard data; req_addr=pc; go FETCH.
  - redirect: pc=redirect_pc (latest wins); rvalid in same cycle still exits to FETCH with req_addr=redirect_pc.
- Redirect has priority over id_stall and over rvalid; IF/ID is flushed even if stalled.
- PC arithmetic modulo 2^32; pc+4 wraps 32'hFFFF_FFFC -> 0 without error.
- imem_rvalid outside an outstanding request (HOLD) is ignored.
- Reset mid-operation: immediate return to reset values; any in-flight response after release is the memory's responsibility to suppress (memory shares rst_n).

Decomposition:
- Shared package (mips_pkg): NOP_INSTR constant, RESET_PC default, fetch state enum {FETCH, HOLD, DROP}, word width constant 32.
- Single module. The IF/ID+skid pair is small; no sub-module required.

Test Plan:
- Reset: hold rst_n=0 3 cycles, release -> cycle 1 imem_req=1, imem_addr=0, id_valid=0, instr=0, PC_4=0.
- Streaming: 1-cycle memory returning addr+0x100 -> instr sequence 0x100,0x104,0x108 with PC_4 4,8,12, one per cycle, id_valid continuously 1.
- Stall/skid: id_stall=1 for 3 cycles while response 0x104 arrives -> instr holds 0x100/PC_4=4, imem_req=0; on release instr=0x104/PC_4=8 next cycle, no instruction lost or duplicated.
- Redirect during outstanding request (3-cycle memory): redirect=1, redirect_pc=0x400 in cycle 1 -> imem_addr stays old until rvalid, response discarded, next imem_addr=0x400, first id_valid instr has PC_4=0x404.
- Redirect coincident with rvalid and id_stall=1 -> response discarded, id_valid=0 next cycle, imem_addr=redirect_pc next cycle.
- Wrap + reset: pc=0xFFFF_FFFC fetch -> PC_4=0, next imem_addr=0; assert rst_n=0 mid-HOLD -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and fetch state encoding for the MIPS pipeline.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] MIPS_NOP = 32'h0000_0000;
  localparam logic [WORD_W-1:0] MIPS_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage owning the PC, one-outstanding imem requests, IF/ID register and a one-entry skid.
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   imem_req, imem_addr        request/word-aligned address to instruction memory
//   imem_rvalid, imem_rdata    instruction memory response
//   id_stall                   decode cannot accept a new instruction
//   redirect, redirect_pc      squash and restart fetch at redirect_pc
//   instr, PC_4, id_valid      IF/ID register contents for decode
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = mips_pkg::MIPS_RESET_PC,
  parameter logic [WORD_W-1:0] NOP_INSTR = mips_pkg::MIPS_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] PC_4,
  output logic              id_valid
);
  fetch_state_t r_state, w_state;
  logic [WORD_W-1:0] r_pc, r_req_addr, r_instr, r_pc_4, r_skid_instr, r_skid_pc_4;
  logic [WORD_W-1:0] w_pc, w_req_addr, w_instr, w_pc_4, w_skid_instr, w_skid_pc_4;
  logic r_id_valid, w_id_valid;
  logic w_slot_free;
  logic [WORD_W-1:0] w_redir_pc, w_pc_inc;

  assign imem_req  = r_state != HOLD;
  assign imem_addr = r_req_addr;
  assign instr     = r_instr;
  assign PC_4      = r_pc_4;
  assign id_valid  = r_id_valid;

  always_comb begin
    w_slot_free  = !r_id_valid || !id_stall;
    w_redir_pc   = redirect_pc & ~32'd3;
    w_pc_inc     = r_pc + 32'd4;
    w_state      = r_state;
    w_pc         = r_pc;
    w_req_addr   = r_req_addr;
    w_instr      = r_instr;
    w_pc_4       = r_pc_4;
    w_id_valid   = r_id_valid;
    w_skid_instr = r_skid_instr;
    w_skid_pc_4  = r_skid_pc_4;
    case (r_state)
      FETCH: begin
        if (redirect) begin
          w_id_valid = 1'b0;
          w_instr    = NOP_INSTR;
          w_pc       = w_redir_pc;
          // Without a response the old request is still outstanding; its address must stay put.
          if (imem_rvalid) w_req_addr = w_redir_pc;
          else w_state = DROP;
        end else if (imem_rvalid && w_slot_free) begin
          w_instr    = imem_rdata;
          w_pc_4     = w_pc_inc;
          w_id_valid = 1'b1;
          w_pc       = w_pc_inc;
          w_req_addr = w_pc_inc;
        end else if (imem_rvalid) begin
          w_skid_instr = imem_rdata;
          w_skid_pc_4  = w_pc_inc;
          w_pc         = w_pc_inc;
          w_req_addr   = w_pc_inc;
          w_state      = HOLD;
        end else if (w_slot_free) begin
          w_id_valid = 1'b0;
          w_instr    = NOP_INSTR;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_id_valid = 1'b0;
          w_instr    = NOP_INSTR;
          w_pc       = w_redir_pc;
          w_req_addr = w_redir_pc;
          w_state    = FETCH;
        end else if (!id_stall) begin
          w_instr    = r_skid_instr;
          w_pc_4     = r_skid_pc_4;
          w_id_valid = 1'b1;
          w_state    = FETCH;
        end
      end
      default: begin
        w_id_valid = 1'b0;
        w_instr    = NOP_INSTR;
        if (redirect) w_pc = w_redir_pc;
        if (imem_rvalid) begin
          w_req_addr = redirect ? w_redir_pc : r_pc;
          w_state    = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc_4       <= '0;
      r_id_valid   <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc_4  <= '0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_req_addr   <= w_req_addr;
      r_instr      <= w_instr;
      r_pc_4       <= w_pc_4;
      r_id_valid   <= w_id_valid;
      r_skid_instr <= w_skid_instr;
      r_skid_pc_4  <= w_skid_pc_4;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req, imem_rvalid, id_stall, redirect, id_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, PC_4;
  int vectors = 0;
  int miscompares = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_stall(id_stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr), .PC_4(PC_4),
    .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] ins, input logic [31:0] pc4);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, vld});
    chk({tag, ".instr"}, instr, ins);
    chk({tag, ".pc4"}, PC_4, pc4);
  endtask

  task automatic step(input logic rv, input logic [31:0] rd, input logic st,
                      input logic rdr, input logic [31:0] rp);
    imem_rvalid = rv;
    imem_rdata  = rd;
    id_stall    = st;
    redirect    = rdr;
    redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk_all("reset", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1, 32'h100, 0, 0, 0); chk_all("stream0", 1, 32'h4, 1, 32'h100, 32'h4);
    step(1, 32'h104, 0, 0, 0); chk_all("stream1", 1, 32'h8, 1, 32'h104, 32'h8);
    step(1, 32'h108, 0, 0, 0); chk_all("stream2", 1, 32'hC, 1, 32'h108, 32'hC);
    step(0, 32'h0, 0, 0, 0);   chk_all("bubble", 1, 32'hC, 0, 32'h0, 32'hC);

    do_reset();
    step(1, 32'h100, 0, 0, 0);  chk_all("skid0", 1, 32'h4, 1, 32'h100, 32'h4);
    step(1, 32'h104, 1, 0, 0);  chk_all("skid_st1", 0, 32'h8, 1, 32'h100, 32'h4);
    step(1, 32'hDEAD, 1, 0, 0); chk_all("skid_st2", 0, 32'h8, 1, 32'h100, 32'h4);
    step(0, 32'h0, 1, 0, 0);    chk_all("skid_st3", 0, 32'h8, 1, 32'h100, 32'h4);
    step(0, 32'h0, 0, 0, 0);    chk_all("skid_rel", 1, 32'h8, 1, 32'h104, 32'h8);
    step(1, 32'h108, 0, 0, 0);  chk_all("skid_next", 1, 32'hC, 1, 32'h108, 32'hC);

    do_reset();
    step(1, 32'h100, 0, 0, 0);      chk_all("rd0", 1, 32'h4, 1, 32'h100, 32'h4);
    step(0, 32'h0, 0, 1, 32'h200);  chk_all("rd_drop1", 1, 32'h4, 0, 32'h0, 32'h4);
    step(0, 32'h0, 0, 1, 32'h403);  chk_all("rd_drop2", 1, 32'h4, 0, 32'h0, 32'h4);
    step(1, 32'h104, 0, 0, 0);      chk_all("rd_discard", 1, 32'h400, 0, 32'h0, 32'h4);
    step(0, 32'h0, 0, 0, 0);        chk_all("rd_wait", 1, 32'h400, 0, 32'h0, 32'h4);
    step(1, 32'h500, 0, 0, 0);      chk_all("rd_first", 1, 32'h404, 1, 32'h500, 32'h404);

    step(1, 32'h999, 1, 1, 32'h800); chk_all("rd_coinc", 1, 32'h800, 0, 32'h0, 32'h404);

    step(1, 32'h777, 0, 1, 32'hFFFF_FFFC); chk_all("wrap_redir", 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h404);
    step(1, 32'h1234, 0, 0, 0);            chk_all("wrap", 1, 32'h0, 1, 32'h1234, 32'h0);
    step(1, 32'h5678, 1, 0, 0);            chk_all("wrap_hold", 0, 32'h4, 1, 32'h1234, 32'h0);
    step(0, 32'h0, 1, 1, 32'h40);          chk_all("hold_redir", 1, 32'h40, 0, 32'h0, 32'h0);
    step(1, 32'h4444, 0, 0, 0);            chk_all("post_hold", 1, 32'h44, 1, 32'h4444, 32'h44);
    step(1, 32'h4448, 1, 0, 0);            chk_all("hold2", 0, 32'h48, 1, 32'h4444, 32'h44);

    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1, 32'h0, 0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
